sum_tx: RTL and testbench
=========================

SUM_TX -- requirements
Module: sum_tx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 4, meaning clock cycles per serial bit; legal range 2..65535.
REQ-002 SHALL provide port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide port in_valid  input  1  upstream sum/carry pair is valid.
REQ-005 SHALL provide port in_data  input  8  8-bit sum from the adder stage.
REQ-006 SHALL provide port in_carry  input  1  carry-out from the adder stage.
REQ-007 SHALL provide port in_ready  output  1  block can accept a pair this cycle.
REQ-008 SHALL provide port tx  output  1  registered serial line, idle high.
REQ-009 SHALL provide port busy  output  1  frame in progress.
REQ-010 SHALL provide port frame_cnt  output  8  count of completed frames.

Function
REQ-011 SHALL implement states IDLE, START, DATA, CARRY, STOP.
REQ-012 SHALL drive in_ready=1 only in IDLE, 0 in all other states; busy SHALL equal NOT in_ready.
REQ-013 SHALL accept a pair on a cycle with in_valid=1 and in_ready=1: latch in_data and in_carry into a shift register and go to START on the next edge.
REQ-014 SHALL ignore in_valid and input data while not in IDLE; a producer holding in_valid is served once the block returns to IDLE.
REQ-015 SHALL transmit each frame as: start bit 0, in_data bits 0..7 (LSB first), in_carry, stop bit 1 (11 bits total).
REQ-016 SHALL hold each bit on tx for exactly CLKS_PER_BIT cycles using a baud counter that resets to 0 at every bit boundary.
REQ-017 SHALL, for acceptance in cycle T, drive tx=0 from cycle T+1 and tx=1 (stop) in cycles T+10*CLKS_PER_BIT+1 .. T+11*CLKS_PER_BIT.
REQ-018 SHALL return to IDLE so that in_ready=1 in cycle T+11*CLKS_PER_BIT+1; back-to-back frames SHALL therefore have no idle gap beyond the stop bit when in_valid is held high.
REQ-019 SHALL step DATA through bit index 0..7 with a 3-bit counter, moving to CARRY after index 7 completes.
REQ-020 SHALL increment frame_cnt by 1 on the final cycle of STOP, wrapping 255 -> 0.
REQ-021 SHALL drive tx=1 in IDLE.
REQ-022 SHALL not alter the latched payload during a frame even if in_data changes.

Reset
REQ-023 SHALL, when rst=1 at a clock edge, set state=IDLE, tx=1, baud counter=0, bit index=0, shift register=0, frame_cnt=0; hence in_ready=1, busy=0 in the following cycle.
REQ-024 SHALL abort any frame in progress on reset without incrementing frame_cnt; tx SHALL be 1 from the cycle after reset.
REQ-025 SHALL give rst priority over a simultaneous in_valid; the pair presented in the reset cycle is not accepted.

Verification
REQ-026 SHALL cover: CLKS_PER_BIT=4, in_data=0xA5, in_carry=1, one-cycle in_valid -> tx sequence 0,1,0,1,0,0,1,0,1,1,1, each held 4 cycles, frame_cnt 0->1.
REQ-027 SHALL cover: in_valid held high with 0x00/carry 0 then 0xFF/carry 1 -> two frames, second start bit immediately after first stop bit, in_ready high exactly one cycle between them.
REQ-028 SHALL cover: in_data changed to 0x3C mid-frame after accepting 0x81 -> tx still emits 0x81 payload, new value not accepted until IDLE.
REQ-029 SHALL cover: rst asserted during DATA bit 4 -> tx=1, in_ready=1 next cycle, frame_cnt unchanged.
REQ-030 SHALL cover: 256 frames sent -> frame_cnt wraps to 0x00.
REQ-031 SHALL cover: rst and in_valid asserted together -> no frame started, tx stays 1.

Source files
------------

// File: rtl/sum_tx.sv
// Serialises an 8-bit sum plus its carry into an 11-bit frame:
// start 0, data LSB first, carry, stop 1. tx is registered and idles high.
module sum_tx #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   input  logic       in_carry,
   output logic       in_ready,
   output logic       tx,
   output logic       busy,
   output logic [7:0] frame_cnt
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      CARRY,
      STOP
   } state_t;

   localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

   state_t      state;
   state_t      state_next;
   logic [15:0] baud_cnt;
   logic [2:0]  bit_idx;
   logic [8:0]  shreg;
   logic        accept;
   logic        bit_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      bit_done   = (baud_cnt == BAUD_LAST);
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = START;
            end
         end
         START: begin
            if (bit_done) begin
               state_next = DATA;
            end
         end
         DATA: begin
            if (bit_done && (bit_idx == 3'd7)) begin
               state_next = CARRY;
            end
         end
         CARRY: begin
            if (bit_done) begin
               state_next = STOP;
            end
         end
         STOP: begin
            if (bit_done) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      accept = in_ready & in_valid;
   end

   assign busy = ~in_ready;

   // tx is loaded one bit ahead: at each bit boundary the next bit goes out
   // of shreg[0], so after the start bit plus eight data bits the carry is
   // sitting at position 0 ready for the CARRY slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx        <= 1'b1;
         baud_cnt  <= 16'd0;
         bit_idx   <= 3'd0;
         shreg     <= 9'd0;
         frame_cnt <= 8'd0;
      end else if (state == IDLE) begin
         tx       <= 1'b1;
         baud_cnt <= 16'd0;
         bit_idx  <= 3'd0;
         if (accept) begin
            shreg <= {in_carry, in_data};
            tx    <= 1'b0;
         end
      end else if (bit_done) begin
         baud_cnt <= 16'd0;
         shreg    <= {1'b0, shreg[8:1]};
         if ((state == CARRY) || (state == STOP)) begin
            tx <= 1'b1;
         end else begin
            tx <= shreg[0];
         end
         if (state == DATA) begin
            bit_idx <= bit_idx + 3'd1;
         end
         if (state == STOP) begin
            frame_cnt <= frame_cnt + 8'd1;
         end
      end else begin
         baud_cnt <= baud_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_sum_tx.sv
// Directed bench for sum_tx: expected frames are queued when a pair is
// offered and checked bit-by-bit against tx as the DUT shifts them out.
module tb_sum_tx;

   localparam int C = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_carry;
   logic       in_ready;
   logic       tx;
   logic       busy;
   logic [7:0] frame_cnt;

   int          tests_run    = 0;
   int          tests_failed = 0;
   logic [10:0] exp_q[$];
   logic [7:0]  exp_cnt;

   sum_tx #(.CLKS_PER_BIT(C)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_carry (in_carry),
      .in_ready (in_ready),
      .tx       (tx),
      .busy     (busy),
      .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      tests_run++;
      assert (obs === expv) else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Offers one pair at the next falling edge; returns at the falling edge of
   // the first cycle after acceptance (the first start-bit cycle).
   task automatic applyStimulus(input logic [7:0] d, input logic c, input bit hold);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_carry = c;
      checkOutput("ready_at_accept", 16'(in_ready), 16'd1);
      exp_q.push_back({1'b1, c, d, 1'b0});
      @(negedge clk);
      if (!hold) begin
         in_valid = 1'b0;
      end
   endtask

   // Checks the oldest queued frame starting at the current falling edge and
   // ends at the falling edge of the first cycle back in IDLE.
   task automatic checkFrame(input string tag);
      logic [10:0] f;
      if (exp_q.size() == 0) begin
         checkOutput({tag, "_queue_empty"}, 16'd1, 16'd0);
         return;
      end
      f = exp_q.pop_front();
      for (int b = 0; b < 11; b++) begin
         for (int k = 0; k < C; k++) begin
            checkOutput({tag, "_tx"}, 16'(tx), 16'(f[b]));
            if (k == 0) begin
               checkOutput({tag, "_busy"}, 16'(busy), 16'd1);
               checkOutput({tag, "_ready_low"}, 16'(in_ready), 16'd0);
            end
            @(negedge clk);
         end
      end
      exp_cnt++;
      checkOutput({tag, "_ready_end"}, 16'(in_ready), 16'd1);
      checkOutput({tag, "_busy_end"}, 16'(busy), 16'd0);
      checkOutput({tag, "_tx_idle"}, 16'(tx), 16'd1);
      checkOutput({tag, "_frame_cnt"}, 16'(frame_cnt), 16'(exp_cnt));
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      in_carry = 1'b0;
      exp_cnt  = 8'd0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("reset_tx", 16'(tx), 16'd1);
      checkOutput("reset_ready", 16'(in_ready), 16'd1);
      checkOutput("reset_busy", 16'(busy), 16'd0);
      checkOutput("reset_frame_cnt", 16'(frame_cnt), 16'd0);
      rst = 1'b0;

      // Abort in DATA bit 4: 0xEF has bit 4 clear so tx is low there.
      applyStimulus(8'hEF, 1'b0, 1'b0);
      exp_q.delete();
      repeat (5 * C + 1) @(negedge clk);
      checkOutput("abort_bit4_tx", 16'(tx), 16'd0);
      checkOutput("abort_busy_before", 16'(busy), 16'd1);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("abort_tx", 16'(tx), 16'd1);
      checkOutput("abort_ready", 16'(in_ready), 16'd1);
      checkOutput("abort_busy", 16'(busy), 16'd0);
      checkOutput("abort_frame_cnt", 16'(frame_cnt), 16'(exp_cnt));
      rst = 1'b0;
      repeat (12 * C) begin
         @(negedge clk);
         checkOutput("abort_stays_idle", 16'(tx), 16'd1);
      end

      // Reset wins over a simultaneous valid pair.
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h77;
      in_carry = 1'b1;
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      checkOutput("rstvalid_ready", 16'(in_ready), 16'd1);
      checkOutput("rstvalid_tx", 16'(tx), 16'd1);
      repeat (2 * C) begin
         @(negedge clk);
         checkOutput("rstvalid_tx_idle", 16'(tx), 16'd1);
         checkOutput("rstvalid_busy", 16'(busy), 16'd0);
      end

      applyStimulus(8'hA5, 1'b1, 1'b0);
      checkFrame("a5");

      // Back-to-back with in_valid held: next pair accepted in the one IDLE cycle.
      applyStimulus(8'h00, 1'b0, 1'b1);
      in_data  = 8'hFF;
      in_carry = 1'b1;
      exp_q.push_back({1'b1, 1'b1, 8'hFF, 1'b0});
      checkFrame("b2b_first");
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("b2b_ready_one_cycle", 16'(in_ready), 16'd0);
      checkFrame("b2b_second");

      // Payload changes mid-frame must not leak into the frame on the line.
      applyStimulus(8'h81, 1'b0, 1'b1);
      in_data  = 8'h3C;
      in_carry = 1'b0;
      exp_q.push_back({1'b1, 1'b0, 8'h3C, 1'b0});
      checkFrame("hold81");
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("hold_ready_low", 16'(in_ready), 16'd0);
      checkFrame("then3c");

      // Counter wrap over 256 frames from a fresh reset.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst     = 1'b0;
      exp_cnt = 8'd0;
      checkOutput("wrap_start_cnt", 16'(frame_cnt), 16'd0);
      for (int n = 0; n < 256; n++) begin
         applyStimulus(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
         checkFrame("wrap");
      end
      checkOutput("wrap_final_cnt", 16'(frame_cnt), 16'h00);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
